trig_sched: RTL and testbench
=============================

TRIG_SCHED -- requirements
Module: trig_sched

Interface
REQ-001 Parameter: ROM_LAT, default 2, read latency in cycles from rom_addr to rom_cos/rom_sin valid (1..4).
REQ-002 Parameter: SPEED, default 6, unsigned 4-bit velocity scale.
REQ-003 clk  in  1  clock; all logic rising-edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 frame_tick  in  1  one-cycle pulse requesting one velocity update.
REQ-006 p_dir  in  9  player heading, degrees 0..359.
REQ-007 o_dir  in  9  opponent heading, degrees 0..359.
REQ-008 rom_addr  out  9  address to the single shared cos/sin ROM pair, registered.
REQ-009 rom_cos, rom_sin  in  11 each  signed two's-complement table data.
REQ-010 p_vx, p_vy, o_vx, o_vy  out  15 each  signed velocities, registered.
REQ-011 vel_valid  out  1  one-cycle pulse when all four velocities update together.
REQ-012 busy  out  1  high from the cycle after an accepted tick until the vel_valid cycle inclusive.
REQ-013 dir_err  out  1  sticky flag set when a latched heading is above 359.
REQ-014 overrun_cnt  out  8  saturating count of dropped ticks.

Function
REQ-015 FSM states SHALL be IDLE, ISSUE_P, ISSUE_O, WAIT, CALC; reset state IDLE.
REQ-016 IDLE + frame_tick: latch p_dir/o_dir, go to ISSUE_P next cycle; no tick: stay IDLE.
REQ-017 ISSUE_P drives rom_addr = latched p_dir; next state ISSUE_O unconditionally.
REQ-018 ISSUE_O drives rom_addr = latched o_dir; next state WAIT.
REQ-019 Player data SHALL be captured exactly ROM_LAT cycles after the ISSUE_P cycle; opponent data exactly ROM_LAT cycles after the ISSUE_O cycle (back-to-back pipelined reads).
REQ-020 WAIT exits to CALC in the cycle after opponent data capture; CALC lasts one cycle, then IDLE.
REQ-021 vel_valid and new velocities SHALL appear in the cycle after CALC: total latency ROM_LAT+4 cycles from the tick cycle.
REQ-022 vx = SPEED * cos; vy = -(SPEED * sin); signed, 11-bit data sign-extended to 15 bits before multiply; no saturation needed (max |1023*15| fits).
REQ-023 Velocity outputs SHALL hold their value between vel_valid pulses.
REQ-024 Latched heading above 359: rom_addr driven 0 for that requester, dir_err set; cleared only by rst.
REQ-025 frame_tick while busy or in IDLE-exit cycle already committed: tick dropped, overrun_cnt increments, saturates at 255; no queued update.
REQ-026 frame_tick in the same cycle vel_valid pulses SHALL be accepted (FSM already IDLE), not counted as overrun.
REQ-027 Heading inputs changing mid-sequence SHALL NOT affect the in-flight update.
REQ-028 rom_addr in IDLE/WAIT/CALC SHALL hold its last value (no spurious toggling requirement beyond that).

Reset
REQ-029 rst SHALL return FSM to IDLE from any state, aborting any in-flight update without a vel_valid pulse.
REQ-030 Reset values: rom_addr 0, all velocities 0, vel_valid 0, busy 0, dir_err 0, overrun_cnt 0.
REQ-031 ROM data arriving after rst from an aborted read SHALL be ignored.

Structure
REQ-032 Shared package game_pkg SHALL hold DIR_MAX (360), TRIG_W (11), VEL_W (15) and the FSM state enum.
REQ-033 One sub-module vel_scale (registered sign-extend, multiply by SPEED, optional negate) SHALL be instantiated twice, player and opponent.

Verification
REQ-034 ROM_LAT=2, tick with p_dir=0 (cos=256,sin=0), o_dir=90 (cos=0,sin=256) -> vel_valid at tick+6; p_vx=1536, p_vy=0, o_vx=0, o_vy=-1536.
REQ-035 Negative data: p_dir=180 (cos=-256) -> p_vx=-1536, sign correct across all 15 bits.
REQ-036 Second tick at tick+3 -> dropped, overrun_cnt=1, exactly one vel_valid; 300 such drops -> overrun_cnt=255.
REQ-037 p_dir=400 -> rom_addr=0 in ISSUE_P cycle, dir_err=1 persists until rst.
REQ-038 rst asserted at tick+3 -> no vel_valid, all outputs 0 next cycle, next tick completes normally.
REQ-039 ROM_LAT=1 and ROM_LAT=4 rerun of REQ-034 -> vel_valid at tick+5 and tick+8 respectively.

Source files
------------

// File: rtl/game_pkg.sv
// Shared constants, FSM state type and heading helpers for the trig velocity scheduler.
package game_pkg;

  localparam int unsigned DIR_MAX = 360;
  localparam int unsigned DIR_W   = 9;
  localparam int unsigned TRIG_W  = 11;
  localparam int unsigned VEL_W   = 15;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE_P,
    ISSUE_O,
    WAIT,
    CALC
  } sched_state_e;

  function automatic logic dir_bad(input logic [DIR_W-1:0] dir);
    return dir >= DIR_W'(DIR_MAX);
  endfunction

  // Out-of-range headings read table entry 0 instead of aliasing into unused ROM space.
  function automatic logic [DIR_W-1:0] dir_addr(input logic [DIR_W-1:0] dir);
    return dir_bad(dir) ? '0 : dir;
  endfunction

endpackage

// File: rtl/vel_scale.sv
// Scales one cos/sin sample pair by SPEED into registered vx = SPEED*cos, vy = -(SPEED*sin).
module vel_scale
  import game_pkg::*;
#(
  parameter int unsigned SPEED = 6
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic signed [TRIG_W-1:0] cos_in,
  input  logic signed [TRIG_W-1:0] sin_in,
  output logic signed [VEL_W-1:0]  vx,
  output logic signed [VEL_W-1:0]  vy
);

  localparam logic signed [VEL_W-1:0] SpeedExt = $signed({{(VEL_W-4){1'b0}}, 4'(SPEED)});

  logic signed [VEL_W-1:0] cos_ext;
  logic signed [VEL_W-1:0] sin_ext;
  logic signed [VEL_W-1:0] cos_prod;
  logic signed [VEL_W-1:0] sin_prod;

  always_comb begin
    cos_ext  = $signed({{(VEL_W-TRIG_W){cos_in[TRIG_W-1]}}, cos_in});
    sin_ext  = $signed({{(VEL_W-TRIG_W){sin_in[TRIG_W-1]}}, sin_in});
    // |1023 * 15| < 2^14, so the 15-bit product never wraps.
    cos_prod = cos_ext * SpeedExt;
    sin_prod = sin_ext * SpeedExt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vx <= '0;
      vy <= '0;
    end else if (en) begin
      vx <= cos_prod;
      vy <= -sin_prod;
    end
  end

endmodule

// File: rtl/trig_sched.sv
// Per-frame velocity scheduler: two pipelined reads of a shared cos/sin ROM, then scaling.
module trig_sched
  import game_pkg::*;
#(
  parameter int unsigned ROM_LAT = 2,
  parameter int unsigned SPEED   = 6
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     frame_tick,
  input  logic [DIR_W-1:0]         p_dir,
  input  logic [DIR_W-1:0]         o_dir,
  output logic [DIR_W-1:0]         rom_addr,
  input  logic signed [TRIG_W-1:0] rom_cos,
  input  logic signed [TRIG_W-1:0] rom_sin,
  output logic signed [VEL_W-1:0]  p_vx,
  output logic signed [VEL_W-1:0]  p_vy,
  output logic signed [VEL_W-1:0]  o_vx,
  output logic signed [VEL_W-1:0]  o_vy,
  output logic                     vel_valid,
  output logic                     busy,
  output logic                     dir_err,
  output logic [7:0]               overrun_cnt
);

  localparam int unsigned SrW = ROM_LAT + 1;

  sched_state_e            state_q;
  logic [DIR_W-1:0]        o_dir_q;
  // Bit k set means the player read was issued k+1 cycles ago; the opponent read trails by one.
  logic [SrW-1:0]          issue_sr_q;
  logic                    p_cap;
  logic                    o_cap;
  logic                    calc;
  logic signed [TRIG_W-1:0] p_cos_q;
  logic signed [TRIG_W-1:0] p_sin_q;
  logic signed [TRIG_W-1:0] o_cos_q;
  logic signed [TRIG_W-1:0] o_sin_q;

  assign p_cap = issue_sr_q[ROM_LAT-1];
  assign o_cap = issue_sr_q[ROM_LAT];
  assign calc  = (state_q == CALC);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      o_dir_q     <= '0;
      rom_addr    <= '0;
      issue_sr_q  <= '0;
      vel_valid   <= 1'b0;
      busy        <= 1'b0;
      dir_err     <= 1'b0;
      overrun_cnt <= '0;
    end else begin
      issue_sr_q <= SrW'({issue_sr_q, state_q == ISSUE_P});
      vel_valid  <= calc;
      if (vel_valid) busy <= 1'b0;

      unique case (state_q)
        IDLE: begin
          if (frame_tick) begin
            state_q  <= ISSUE_P;
            o_dir_q  <= o_dir;
            // Address registered here so it is already valid during ISSUE_P.
            rom_addr <= dir_addr(p_dir);
            busy     <= 1'b1;
            if (dir_bad(p_dir) || dir_bad(o_dir)) dir_err <= 1'b1;
          end
        end
        ISSUE_P: begin
          rom_addr <= dir_addr(o_dir_q);
          state_q  <= ISSUE_O;
        end
        ISSUE_O: state_q <= WAIT;
        WAIT:    if (o_cap) state_q <= CALC;
        CALC:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase

      if (frame_tick && (state_q != IDLE) && (overrun_cnt != 8'hFF)) begin
        overrun_cnt <= overrun_cnt + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      p_cos_q <= '0;
      p_sin_q <= '0;
      o_cos_q <= '0;
      o_sin_q <= '0;
    end else begin
      if (p_cap) begin
        p_cos_q <= rom_cos;
        p_sin_q <= rom_sin;
      end
      if (o_cap) begin
        o_cos_q <= rom_cos;
        o_sin_q <= rom_sin;
      end
    end
  end

  vel_scale #(
    .SPEED(SPEED)
  ) u_p_scale (
    .clk   (clk),
    .rst   (rst),
    .en    (calc),
    .cos_in(p_cos_q),
    .sin_in(p_sin_q),
    .vx    (p_vx),
    .vy    (p_vy)
  );

  vel_scale #(
    .SPEED(SPEED)
  ) u_o_scale (
    .clk   (clk),
    .rst   (rst),
    .en    (calc),
    .cos_in(o_cos_q),
    .sin_in(o_sin_q),
    .vx    (o_vx),
    .vy    (o_vy)
  );

endmodule

// File: tb/tb_trig_sched.sv
// Directed bench for trig_sched: three instances (ROM_LAT 2, 1, 4) share clock, reset and stimulus.
module tb_trig_sched;

  logic clk = 1'b0;
  logic rst;
  logic frame_tick;
  logic [8:0] p_dir;
  logic [8:0] o_dir;

  int n_checks = 0;
  int n_fail   = 0;
  int vv_cnt;
  int vv4_cnt;

  always #5 clk = ~clk;

  // Per-instance signals: suffix is the ROM latency.
  logic [8:0] addr2, addr1, addr4;
  logic signed [10:0] cos2, sin2, cos1, sin1, cos4, sin4;
  logic signed [14:0] pvx2, pvy2, ovx2, ovy2;
  logic signed [14:0] pvx1, pvy1, ovx1, ovy1;
  logic signed [14:0] pvx4, pvy4, ovx4, ovy4;
  logic vv2, vv1, vv4, busy2, busy1, busy4, derr2, derr1, derr4;
  logic [7:0] ovr2, ovr1, ovr4;

  function automatic logic signed [10:0] cos_of(input logic [8:0] a);
    case (a)
      9'd0:    cos_of = 11'sd256;
      9'd90:   cos_of = 11'sd0;
      9'd180:  cos_of = -11'sd256;
      9'd270:  cos_of = 11'sd0;
      default: cos_of = 11'sd7;
    endcase
  endfunction

  function automatic logic signed [10:0] sin_of(input logic [8:0] a);
    case (a)
      9'd0:    sin_of = 11'sd0;
      9'd90:   sin_of = 11'sd256;
      9'd180:  sin_of = 11'sd0;
      9'd270:  sin_of = -11'sd256;
      default: sin_of = 11'sd3;
    endcase
  endfunction

  // ROM models with latency 2, 1 and 4.
  logic signed [10:0] c2 [2], s2 [2], c1, s1, c4 [4], s4 [4];
  always @(posedge clk) begin
    c2[0] <= cos_of(addr2);
    s2[0] <= sin_of(addr2);
    c2[1] <= c2[0];
    s2[1] <= s2[0];
    c1    <= cos_of(addr1);
    s1    <= sin_of(addr1);
    c4[0] <= cos_of(addr4);
    s4[0] <= sin_of(addr4);
    for (int i = 1; i < 4; i++) begin
      c4[i] <= c4[i-1];
      s4[i] <= s4[i-1];
    end
  end
  assign cos2 = c2[1];
  assign sin2 = s2[1];
  assign cos1 = c1;
  assign sin1 = s1;
  assign cos4 = c4[3];
  assign sin4 = s4[3];

  trig_sched #(.ROM_LAT(2), .SPEED(6)) u_dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .p_dir(p_dir), .o_dir(o_dir),
    .rom_addr(addr2), .rom_cos(cos2), .rom_sin(sin2),
    .p_vx(pvx2), .p_vy(pvy2), .o_vx(ovx2), .o_vy(ovy2),
    .vel_valid(vv2), .busy(busy2), .dir_err(derr2), .overrun_cnt(ovr2)
  );

  trig_sched #(.ROM_LAT(1), .SPEED(6)) u_dut_l1 (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .p_dir(p_dir), .o_dir(o_dir),
    .rom_addr(addr1), .rom_cos(cos1), .rom_sin(sin1),
    .p_vx(pvx1), .p_vy(pvy1), .o_vx(ovx1), .o_vy(ovy1),
    .vel_valid(vv1), .busy(busy1), .dir_err(derr1), .overrun_cnt(ovr1)
  );

  trig_sched #(.ROM_LAT(4), .SPEED(6)) u_dut_l4 (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .p_dir(p_dir), .o_dir(o_dir),
    .rom_addr(addr4), .rom_cos(cos4), .rom_sin(sin4),
    .p_vx(pvx4), .p_vy(pvy4), .o_vx(ovx4), .o_vy(ovy4),
    .vel_valid(vv4), .busy(busy4), .dir_err(derr4), .overrun_cnt(ovr4)
  );

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach the end of the directed sequence");
    $fatal(1, "timeout");
  end

  initial begin
    rst        = 1'b1;
    frame_tick = 1'b0;
    p_dir      = 9'd0;
    o_dir      = 9'd0;
    cyc(3);
    chk("rst_rom_addr", addr2, 0);
    chk("rst_p_vx", pvx2, 0);
    chk("rst_o_vy", ovy2, 0);
    chk("rst_vel_valid", vv2, 0);
    chk("rst_busy", busy2, 0);
    chk("rst_dir_err", derr2, 0);
    chk("rst_overrun", ovr2, 0);
    rst = 1'b0;
    cyc(2);

    // Basic update, headings changed mid-flight must not matter.
    p_dir = 9'd0; o_dir = 9'd90; frame_tick = 1'b1;
    cyc(1);                                        // tick+1
    frame_tick = 1'b0; p_dir = 9'd270; o_dir = 9'd180;
    chk("t1_addr_issue_p", addr2, 0);
    chk("t1_busy", busy2, 1);
    chk("t1_valid_early", vv2, 0);
    cyc(1);                                        // tick+2
    chk("t1_addr_issue_o", addr2, 90);
    cyc(3);                                        // tick+5
    chk("t1_addr_hold", addr2, 90);
    chk("t1_valid_tick5", vv2, 0);
    chk("l1_valid_tick5", vv1, 1);
    chk("l1_p_vx", pvx1, 1536);
    chk("l1_o_vy", ovy1, -1536);
    cyc(1);                                        // tick+6
    chk("t1_valid", vv2, 1);
    chk("t1_p_vx", pvx2, 1536);
    chk("t1_p_vy", pvy2, 0);
    chk("t1_o_vx", ovx2, 0);
    chk("t1_o_vy", ovy2, -1536);
    chk("t1_busy_at_valid", busy2, 1);
    chk("l1_valid_pulse", vv1, 0);
    cyc(1);                                        // tick+7
    chk("t1_valid_pulse", vv2, 0);
    chk("t1_busy_clear", busy2, 0);
    chk("t1_p_vx_hold", pvx2, 1536);
    chk("l4_valid_tick7", vv4, 0);
    cyc(1);                                        // tick+8
    chk("l4_valid_tick8", vv4, 1);
    chk("l4_p_vx", pvx4, 1536);
    chk("l4_o_vy", ovy4, -1536);
    cyc(2);

    // Negative table data.
    p_dir = 9'd180; o_dir = 9'd270; frame_tick = 1'b1;
    cyc(1);
    frame_tick = 1'b0;
    cyc(5);                                        // tick+6
    chk("t2_valid", vv2, 1);
    chk("t2_p_vx", pvx2, -1536);
    chk("t2_p_vx_bits", {17'b0, pvx2}, 32'h7A00);
    chk("t2_p_vy", pvy2, 0);
    chk("t2_o_vx", ovx2, 0);
    chk("t2_o_vy", ovy2, 1536);
    cyc(3);

    // One dropped tick during busy.
    p_dir = 9'd0; o_dir = 9'd90; frame_tick = 1'b1;
    cyc(1);
    frame_tick = 1'b0;
    vv_cnt = 0;
    for (int i = 1; i <= 10; i++) begin
      if (vv2) vv_cnt++;
      frame_tick = (i == 3);
      cyc(1);
    end
    frame_tick = 1'b0;
    chk("t3_one_valid", vv_cnt, 1);
    chk("t3_overrun_1", ovr2, 1);

    // 100 more updates with three drops each: 301 drops saturate at 255.
    for (int k = 0; k < 100; k++) begin
      frame_tick = 1'b1;
      cyc(4);
      frame_tick = 1'b0;
      cyc(6);
      if (k == 0) chk("t3_overrun_4", ovr2, 4);
    end
    chk("t3_overrun_sat", ovr2, 255);
    chk("t3_l4_overrun_sat", ovr4, 255);

    // Out-of-range player heading.
    p_dir = 9'd400; o_dir = 9'd90; frame_tick = 1'b1;
    cyc(1);
    frame_tick = 1'b0;
    chk("t4_addr_zero", addr2, 0);
    chk("t4_dir_err", derr2, 1);
    cyc(1);
    chk("t4_addr_o", addr2, 90);
    cyc(4);                                        // tick+6
    chk("t4_valid", vv2, 1);
    chk("t4_p_vx", pvx2, 1536);
    cyc(3);

    // Out-of-range opponent heading.
    p_dir = 9'd90; o_dir = 9'd500; frame_tick = 1'b1;
    cyc(1);
    frame_tick = 1'b0;
    chk("t5_addr_p", addr2, 90);
    cyc(1);
    chk("t5_addr_o_zero", addr2, 0);
    cyc(7);
    chk("t5_dir_err_sticky", derr2, 1);

    // Reset mid-flight aborts the update.
    p_dir = 9'd180; o_dir = 9'd90; frame_tick = 1'b1;
    cyc(1);
    frame_tick = 1'b0;
    cyc(2);                                        // tick+3
    rst = 1'b1;
    cyc(1);                                        // tick+4
    chk("t6_rom_addr", addr2, 0);
    chk("t6_p_vx", pvx2, 0);
    chk("t6_p_vy", pvy2, 0);
    chk("t6_o_vx", ovx2, 0);
    chk("t6_o_vy", ovy2, 0);
    chk("t6_valid", vv2, 0);
    chk("t6_busy", busy2, 0);
    chk("t6_dir_err", derr2, 0);
    chk("t6_overrun", ovr2, 0);
    rst = 1'b0;
    vv_cnt  = 0;
    vv4_cnt = 0;
    for (int i = 0; i < 9; i++) begin
      cyc(1);
      if (vv2) vv_cnt++;
      if (vv4) vv4_cnt++;
    end
    chk("t6_no_valid", vv_cnt, 0);
    chk("t6_l4_no_valid", vv4_cnt, 0);
    chk("t6_busy_idle", busy2, 0);

    p_dir = 9'd0; o_dir = 9'd90; frame_tick = 1'b1;
    cyc(1);
    frame_tick = 1'b0;
    cyc(4);                                        // tick+5
    chk("t7_valid_tick5", vv2, 0);
    cyc(1);                                        // tick+6
    chk("t7_valid", vv2, 1);
    chk("t7_p_vx", pvx2, 1536);
    chk("t7_o_vy", ovy2, -1536);
    chk("t7_overrun", ovr2, 0);
    cyc(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
